// File: rtl/writeback_unit.sv
// Writeback stage: WB pipeline register, load extension, retire strobe
// and a per-register pending-write scoreboard with sticky overflow.
module writeback_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        Enable,
   input  logic        Flush,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic        mem_ruwr,
   input  logic [1:0]  mem_wbsel,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_alu,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] mem_pc4,
   input  logic        iss_valid,
   input  logic        iss_ruwr,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  RS1,
   input  logic [4:0]  RS2,
   output logic [4:0]  RD,
   output logic [31:0] DataWr,
   output logic        RUWr,
   output logic        busy_rs1,
   output logic        busy_rs2,
   output logic        sb_ovf
);

   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        wb_ruwr_q, wb_ruwr_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_done_q, wb_done_d;
   logic [1:0]  cnt_q [32];
   logic [1:0]  cnt_d [32];
   logic        ovf_q, ovf_d;

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;
   logic [31:0] result;
   logic        issue;
   logic        squash;
   logic signed [3:0] nxt;
   logic        unused_addr;

   assign unused_addr = ^mem_addr[31:2];

   always_comb begin
      lane_b = mem_rdata[7:0];
      unique case (mem_addr[1:0])
         2'd0: lane_b = mem_rdata[7:0];
         2'd1: lane_b = mem_rdata[15:8];
         2'd2: lane_b = mem_rdata[23:16];
         2'd3: lane_b = mem_rdata[31:24];
      endcase
      lane_h = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      load_val = mem_rdata;
      case (mem_funct3)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_val = {24'd0, lane_b};
         3'b101:  load_val = {16'd0, lane_h};
         default: load_val = mem_rdata;
      endcase
   end

   always_comb begin
      result = mem_alu;
      case (mem_wbsel)
         2'b01:   result = load_val;
         2'b10:   result = mem_pc4;
         default: result = mem_alu;
      endcase
   end

   // A stalled entry retires once; wb_done masks the strobe afterwards.
   assign RUWr = wb_valid_q & wb_ruwr_q & (wb_rd_q != 5'd0) & ~wb_done_q;
   assign RD = wb_rd_q;
   assign DataWr = wb_data_q;

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_rd_d = wb_rd_q;
      wb_ruwr_d = wb_ruwr_q;
      wb_data_d = wb_data_q;
      wb_done_d = wb_done_q;
      if (Enable) begin
         wb_valid_d = mem_valid & ~Flush;
         wb_rd_d = mem_rd;
         wb_ruwr_d = mem_ruwr;
         wb_data_d = result;
         wb_done_d = 1'b0;
      end else if (RUWr) begin
         wb_done_d = 1'b1;
      end
   end

   assign issue = Enable & iss_valid & iss_ruwr & (iss_rd != 5'd0);
   assign squash = Enable & Flush & mem_valid & mem_ruwr
                 & (mem_rd != 5'd0);

   // Net change per register spans -2..+1; saturate into 0..3.
   always_comb begin
      ovf_d = ovf_q;
      nxt = 4'sd0;
      for (int r = 0; r < 32; r++) begin
         nxt = $signed({2'b00, cnt_q[r]});
         if (issue && iss_rd == 5'(r))
            nxt = nxt + 4'sd1;
         if (RUWr && wb_rd_q == 5'(r))
            nxt = nxt - 4'sd1;
         if (squash && mem_rd == 5'(r))
            nxt = nxt - 4'sd1;
         if (r == 0) begin
            cnt_d[r] = 2'd0;
         end else if (nxt > 4'sd3) begin
            cnt_d[r] = 2'd3;
            ovf_d = 1'b1;
         end else if (nxt < 4'sd0) begin
            cnt_d[r] = 2'd0;
            ovf_d = 1'b1;
         end else begin
            cnt_d[r] = nxt[1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_rd_q <= 5'd0;
         wb_ruwr_q <= 1'b0;
         wb_data_q <= 32'd0;
         wb_done_q <= 1'b0;
         ovf_q <= 1'b0;
         for (int r = 0; r < 32; r++)
            cnt_q[r] <= 2'd0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_rd_q <= wb_rd_d;
         wb_ruwr_q <= wb_ruwr_d;
         wb_data_q <= wb_data_d;
         wb_done_q <= wb_done_d;
         ovf_q <= ovf_d;
         for (int r = 0; r < 32; r++)
            cnt_q[r] <= cnt_d[r];
      end
   end

   assign busy_rs1 = (cnt_q[RS1] != 2'd0);
   assign busy_rs2 = (cnt_q[RS2] != 2'd0);
   assign sb_ovf = ovf_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized plus directed bench for writeback_unit against an
// integer-count reference model of the WB entry and scoreboard.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Enable, Flush, mem_valid, mem_ruwr;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_wbsel;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_alu, mem_rdata, mem_pc4;
   logic        iss_valid, iss_ruwr;
   logic [4:0]  iss_rd, RS1, RS2;
   logic [4:0]  RD;
   logic [31:0] DataWr;
   logic        RUWr, busy_rs1, busy_rs2, sb_ovf;

   int n_checks = 0;
   int n_errors = 0;

   bit          m_valid, m_ruwr, m_done, m_ovf;
   int          m_rd;
   logic [31:0] m_data;
   int          m_cnt [32];

   writeback_unit dut (
      .clk(clk), .rst(rst), .Enable(Enable), .Flush(Flush),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_ruwr(mem_ruwr),
      .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3),
      .mem_addr(mem_addr), .mem_alu(mem_alu), .mem_rdata(mem_rdata),
      .mem_pc4(mem_pc4), .iss_valid(iss_valid), .iss_ruwr(iss_ruwr),
      .iss_rd(iss_rd), .RS1(RS1), .RS2(RS2), .RD(RD),
      .DataWr(DataWr), .RUWr(RUWr), .busy_rs1(busy_rs1),
      .busy_rs2(busy_rs2), .sb_ovf(sb_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_result();
      logic [31:0] w;
      int sh;
      if (mem_wbsel == 2'b10) return mem_pc4;
      if (mem_wbsel != 2'b01) return mem_alu;
      case (mem_funct3)
         3'b000, 3'b100: begin
            sh = 8 * int'(mem_addr[1:0]);
            w = (mem_rdata >> sh) & 32'hFF;
            if (mem_funct3 == 3'b000 && w[7]) w = w | 32'hFFFFFF00;
         end
         3'b001, 3'b101: begin
            sh = mem_addr[1] ? 16 : 0;
            w = (mem_rdata >> sh) & 32'hFFFF;
            if (mem_funct3 == 3'b001 && w[15]) w = w | 32'hFFFF0000;
         end
         default: w = mem_rdata;
      endcase
      return w;
   endfunction

   function automatic bit exp_we();
      return m_valid && m_ruwr && m_rd != 0 && !m_done;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_ruwr = 0; m_done = 0; m_ovf = 0;
      m_rd = 0; m_data = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
   endtask

   task automatic model_update();
      int  delta [32];
      bit  we;
      we = exp_we();
      foreach (delta[i]) delta[i] = 0;
      if (Enable && iss_valid && iss_ruwr && iss_rd != 0)
         delta[iss_rd] += 1;
      if (we) delta[m_rd] -= 1;
      if (Enable && Flush && mem_valid && mem_ruwr && mem_rd != 0)
         delta[mem_rd] -= 1;
      for (int r = 1; r < 32; r++) begin
         m_cnt[r] += delta[r];
         if (m_cnt[r] > 3) begin m_cnt[r] = 3; m_ovf = 1; end
         if (m_cnt[r] < 0) begin m_cnt[r] = 0; m_ovf = 1; end
      end
      if (Enable) begin
         m_valid = mem_valid && !Flush;
         m_rd = int'(mem_rd);
         m_ruwr = mem_ruwr;
         m_data = ref_result();
         m_done = 0;
      end else if (we) begin
         m_done = 1;
      end
   endtask

   task automatic compare_outputs();
      chk("RD", 32'(RD), 32'(m_rd));
      chk("DataWr", DataWr, m_data);
      chk("RUWr", 32'(RUWr), 32'(exp_we()));
      chk("busy_rs1", 32'(busy_rs1), 32'(m_cnt[RS1] != 0));
      chk("busy_rs2", 32'(busy_rs2), 32'(m_cnt[RS2] != 0));
      chk("sb_ovf", 32'(sb_ovf), 32'(m_ovf));
   endtask

   task automatic tick();
      #1;
      compare_outputs();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      compare_outputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle();
      Enable = 1; Flush = 0; mem_valid = 0; mem_ruwr = 0;
      mem_rd = 0; mem_wbsel = 0; mem_funct3 = 0; mem_addr = 0;
      mem_alu = 0; mem_rdata = 0; mem_pc4 = 0;
      iss_valid = 0; iss_ruwr = 0; iss_rd = 0; RS1 = 0; RS2 = 0;
   endtask

   task automatic mem_entry(input logic [4:0] rd);
      mem_valid = 1; mem_ruwr = 1; mem_rd = rd;
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid = 1; iss_ruwr = 1; iss_rd = rd;
   endtask

   task automatic no_issue();
      iss_valid = 0; iss_ruwr = 0; iss_rd = 0;
   endtask

   initial begin
      logic [2:0] f3s [6];
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
      idle();
      do_reset();

      // Simple ALU writeback and busy lifetime
      issue(5); RS1 = 5; tick();
      #1 chk("busy5_set", 32'(busy_rs1), 32'd1);
      no_issue(); mem_entry(5); mem_alu = 32'h1234; tick();
      mem_valid = 0;
      #1 chk("alu_RD", 32'(RD), 32'd5);
      chk("alu_data", DataWr, 32'h00001234);
      chk("alu_we", 32'(RUWr), 32'd1);
      tick();
      #1 chk("alu_we_once", 32'(RUWr), 32'd0);
      chk("busy5_clr", 32'(busy_rs1), 32'd0);

      // Load extension
      idle(); issue(6); mem_entry(6); mem_wbsel = 2'b01;
      mem_funct3 = 3'b000; mem_addr = 32'h102; mem_rdata = 32'h00800000;
      tick();
      mem_funct3 = 3'b101; mem_rdata = 32'hBEEF0000;
      #1 chk("lb_data", DataWr, 32'hFFFFFF80);
      tick();
      no_issue(); mem_valid = 0;
      #1 chk("lhu_data", DataWr, 32'h0000BEEF);
      tick();
      #1 chk("load_no_ovf", 32'(sb_ovf), 32'd0);

      // x0 is never written or tracked
      idle(); issue(0); mem_entry(0); tick();
      no_issue(); mem_valid = 0; RS1 = 0;
      #1 chk("x0_we", 32'(RUWr), 32'd0);
      chk("x0_busy", 32'(busy_rs1), 32'd0);
      tick();

      // Stalled entry retires exactly once
      idle(); issue(7); RS1 = 7; tick();
      no_issue(); mem_entry(7); tick();
      Enable = 0; mem_valid = 0;
      #1 chk("stall_c1", 32'(RUWr), 32'd1);
      tick();
      #1 chk("stall_c2", 32'(RUWr), 32'd0);
      chk("stall_busy", 32'(busy_rs1), 32'd0);
      tick();
      #1 chk("stall_c3", 32'(RUWr), 32'd0);
      tick();
      Enable = 1; tick();

      // Issue and retire on one edge; then a squash
      idle(); issue(9); RS1 = 9; tick();
      no_issue(); mem_entry(9); tick();
      mem_valid = 0; issue(9);
      #1 chk("net_we", 32'(RUWr), 32'd1);
      tick();
      no_issue();
      #1 chk("net_busy", 32'(busy_rs1), 32'd1);
      Flush = 1; mem_entry(9); tick();
      Flush = 0; mem_valid = 0;
      #1 chk("sq_we", 32'(RUWr), 32'd0);
      chk("sq_busy", 32'(busy_rs1), 32'd0);
      chk("sq_ovf", 32'(sb_ovf), 32'd0);
      tick();

      // Saturation and reset recovery
      idle(); RS1 = 3;
      for (int i = 0; i < 4; i++) begin issue(3); tick(); end
      no_issue();
      #1 chk("sat_ovf", 32'(sb_ovf), 32'd1);
      chk("sat_busy", 32'(busy_rs1), 32'd1);
      do_reset();
      #1 chk("rst_ovf", 32'(sb_ovf), 32'd0);
      chk("rst_busy", 32'(busy_rs1), 32'd0);

      // Mid-retire reset aborts the strobe
      idle(); mem_entry(4); tick();
      mem_valid = 0; Enable = 0;
      #1 chk("pre_rst_we", 32'(RUWr), 32'd1);
      do_reset();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         Enable = ($urandom_range(0, 3) != 0);
         Flush = ($urandom_range(0, 6) == 0);
         mem_valid = $urandom_range(0, 1);
         mem_ruwr = ($urandom_range(0, 3) != 0);
         mem_rd = 5'($urandom_range(0, 7));
         mem_wbsel = 2'($urandom_range(0, 3));
         mem_funct3 = f3s[$urandom_range(0, 5)];
         mem_addr = $urandom;
         mem_alu = $urandom;
         mem_rdata = $urandom;
         mem_pc4 = $urandom;
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_ruwr = $urandom_range(0, 1);
         iss_rd = 5'($urandom_range(0, 7));
         RS1 = 5'($urandom_range(0, 7));
         RS2 = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 99) == 0) do_reset();
         else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
